// File: rtl/gatelevel_vector_checker_if.sv
// Bus between the vector checker and the environment that owns the DUT.
// The checker sits on the slave modport. The master side issues start and returns the DUT's Z.
interface gatelevel_vector_checker_if #(
    parameter int unsigned N_IN = 5
);
    logic            start;
    logic [N_IN-1:0] vec;
    logic            z_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic            first_fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        output start, z_in,
        input  vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, z_in,
        output vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec
    );
endinterface

// File: rtl/gatelevel_vector_checker.sv
// Sweeps every input vector onto the DUT and holds each one for HOLD_CYCLES cycles.
// On the last cycle of each hold, it compares Z against the truth table and records error statistics.
module gatelevel_vector_checker #(
    parameter int unsigned          N_IN        = 5,
    parameter int unsigned          HOLD_CYCLES = 20,
    parameter logic [N_IN-1:0]      START_VEC   = 5'b10000,
    parameter logic [2**N_IN-1:0]   EXPECTED    = 32'hFFFF0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    gatelevel_vector_checker_if.slave bus
);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CW = N_IN + 1;

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [CW-1:0]     err_q, err_d;
    logic              ffv_q, ffv_d;
    logic [N_IN-1:0]   ffvec_q, ffvec_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= START_VEC;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = APPLY;
                    vec_d   = START_VEC;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ffv_d   = 1'b0;
                    ffvec_d = '0;
                    hold_d  = '0;
                    cnt_d   = '0;
                end
            end
            APPLY: begin
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    if (bus.z_in != EXPECTED[vec_q]) begin
                        err_d = err_q + CW'(1);
                        if (!ffv_q) begin
                            ffv_d   = 1'b1;
                            ffvec_d = vec_q;
                        end
                    end
                    vec_d  = vec_q + N_IN'(1);
                    hold_d = '0;
                    cnt_d  = cnt_q + CW'(1);
                    // pass uses err_d so that a miss on the final vector is counted
                    if (cnt_q == CW'(2**N_IN - 1)) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.vec              = vec_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
endmodule
